stream_demux_1_4: RTL
=====================

Name: stream_demux_1_4

Overview:
- Routes one valid/ready input stream of WIDTH-bit data to one of four output streams, selected per beat by a 2-bit sel.
- This is the distributing counterpart of the team's 4:1 data muxes.
- Each output channel has its own small FIFO, so a stalled consumer blocks only beats addressed to it.
- Used as the fan-out stage in front of four independent datapath lanes.

Parameters:
- WIDTH, 4: data width per beat, >= 1.
- DEPTH, 2: entries per output FIFO; power of 2, >= 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input beat present.
- in_ready  output  1  block accepts the beat this cycle.
- in_data  input  WIDTH  input payload.
- in_sel  input  2  destination channel 0..3; qualified by in_valid.
- out_valid  output  4  bit i: channel i has a beat.
- out_ready  input  4  bit i: consumer i takes the beat.
- out_data  output  4*WIDTH  channel i payload at [i*WIDTH +: WIDTH].

Behaviour:
- Reset: synchronous and active-high; one clock domain (clk). When rst=1 at an edge, all FIFOs are empty, all pointers and counters are 0, and storage is don't-care. After reset: out_valid=4'b0000, out_data=0 and in_ready=1.
- in_ready is combinational: in_ready = !full[in_sel]. It does not depend on in_valid or on out_ready; there is no same-cycle bypass through a full FIFO.
- Push: in_valid && in_ready at an edge writes in_data into FIFO[in_sel]. Other channels are untouched.
- Pop: out_valid[i] && out_ready[i] at an edge removes the head of FIFO[i]. All four channels may pop in the same cycle.
- out_valid[i] = !empty[i]. out_data slice i = head of FIFO[i] when valid, and forced to 0 when empty.
- Latency: a beat accepted at edge N is visible on out_valid/out_data at edge N, i.e. one cycle after the accept cycle. There is no combinational in->out path.
- Ordering: beats to the same channel leave in acceptance order. No ordering is guaranteed across channels.
- Each FIFO uses a read pointer, a write pointer (log2 DEPTH bits, wrapping modulo DEPTH) and an occupancy counter (0..DEPTH). full = (cnt==DEPTH); empty = (cnt==0).
- Simultaneous push and pop on the same non-full, non-empty FIFO: both happen and cnt is unchanged.
- Push into an empty FIFO with out_ready=1: the beat is not visible until the next cycle and no pop occurs that cycle.
- A full FIFO with pop: in_ready stays 0 for that channel during that cycle. The push may land next cycle.
- When in_valid=0, in_sel is ignored. in_ready still reflects the current in_sel.
- Reset mid-operation: all buffered beats are discarded and no output is asserted in the following cycle.
- Protocol assumption on the upstream side: once in_valid=1, in_data and in_sel hold until accepted. The RTL itself does not depend on this.

Decomposition:
- Package stream_demux_pkg:
  - localparam N_CH = 4
  - localparam SEL_W = 2
  - typedef logic [SEL_W-1:0] ch_sel_t
- Sub-module stream_demux_fifo (parameters WIDTH, DEPTH; ports push, pop, wdata, rdata, empty, full).
- The top instantiates four of these in a generate loop and adds the select decode and the in_ready mux.

Test Plan:
- Reset, then idle -> out_valid=0000, out_data=0 and in_ready=1 for every in_sel value.
- in_sel=2, in_data=4'hA, out_ready=0000, one beat -> next cycle out_valid=0100 with slice 2=A. A second beat 4'h5 to channel 2 is accepted. A third beat to channel 2 sees in_ready=0, while in_sel=1 still shows in_ready=1.
- Channel 2 full (A,5), out_ready[2]=1 for two cycles -> outputs A then 5 in order, then out_valid[2]=0. in_ready for sel=2 returns to 1 after the first pop.
- Streaming 8 beats 1..8 to channel 0 with out_ready[0]=1 continuously -> beats appear 1..8 in order, one per cycle, after 1-cycle latency. Pointers wrap with no loss.
- Interleaved sel 0,1,2,3,0,1,2,3 with data 0..7 and all out_ready=1 -> channel i outputs i then i+4. No cross-channel corruption.
- Channels 1 and 3 each holding beats, rst asserted for one cycle mid-stream -> next cycle out_valid=0000, out_data=0, in_ready=1. Old beats never reappear.

Source files
------------

// File: rtl/stream_demux_pkg.sv
// ============================================================================
//  Module   : stream_demux_pkg
//  Brief    : Shared constants and types for the 1:4 stream demultiplexer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package stream_demux_pkg;

    localparam int N_CH  = 4;
    localparam int SEL_W = 2;

    typedef logic [SEL_W-1:0] ch_sel_t;

endpackage : stream_demux_pkg

`default_nettype wire

// File: rtl/stream_demux_fifo.sv
// ============================================================================
//  Module   : stream_demux_fifo
//  Brief    : Per-channel synchronous FIFO with read/write pointers and count.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_demux_fifo
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [WIDTH-1:0]   mem_d [DEPTH];
    logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    logic               w_do_push;
    logic               w_do_pop;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == c_CNT_W'(DEPTH));
    // Empty slots present zero rather than stale storage.
    assign rdata = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        mem_d     = mem_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        cnt_d     = cnt_q;
        w_do_push = push && !full;
        w_do_pop  = pop && !empty;
        if (w_do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + c_PTR_W'(1);
        end
        if (w_do_pop) begin
            rd_ptr_d = rd_ptr_q + c_PTR_W'(1);
        end
        case ({w_do_push, w_do_pop})
            2'b10:   cnt_d = cnt_q + c_CNT_W'(1);
            2'b01:   cnt_d = cnt_q - c_CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage carries no reset; validity is tracked entirely by cnt_q.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule : stream_demux_fifo

`default_nettype wire

// File: rtl/stream_demux_1_4.sv
// ============================================================================
//  Module   : stream_demux_1_4
//  Brief    : Routes one valid/ready stream to four buffered output channels.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_demux_1_4
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    input  logic [SEL_W-1:0]      in_sel,
    output logic [N_CH-1:0]       out_valid,
    input  logic [N_CH-1:0]       out_ready,
    output logic [N_CH*WIDTH-1:0] out_data
);

    logic [N_CH-1:0] w_full;
    logic [N_CH-1:0] w_empty;
    logic [N_CH-1:0] w_push;
    logic [N_CH-1:0] w_pop;
    ch_sel_t         w_sel;

    assign w_sel     = in_sel;
    // Ready tracks only the addressed FIFO; no bypass through a full one.
    assign in_ready  = !w_full[w_sel];
    assign out_valid = ~w_empty;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        assign w_push[gi] = in_valid && in_ready && (w_sel == ch_sel_t'(gi));
        assign w_pop[gi]  = out_valid[gi] && out_ready[gi];

        stream_demux_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (w_push[gi]),
            .pop   (w_pop[gi]),
            .wdata (in_data),
            .rdata (out_data[gi*WIDTH +: WIDTH]),
            .empty (w_empty[gi]),
            .full  (w_full[gi])
        );
    end

endmodule : stream_demux_1_4

`default_nettype wire
